// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: the register
// offsets, the STATUS bit layout and the transmit FSM state encoding.
package mmio_uart_pkg;

    // Register offsets within the 16-byte window (word index dataadr[3:2])
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;

    // STATUS bit positions
    localparam int ST_ACTIVE    = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_FULL      = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/mmio_tx_fifo.sv
// Small synchronous FIFO for bytes awaiting transmission. The read side is
// first-word-fall-through: dout shows the oldest entry whenever non-empty.
// A push while full is accepted only if a pop happens in the same cycle.
module mmio_tx_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [CW-1:0] wptr;
    logic [CW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    // Pointers carry one extra wrap bit so their difference is the occupancy
    assign count   = wptr - rptr;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + CW'(1);
            if (do_pop)  rptr <= rptr + CW'(1);
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers alone define which entries are valid.
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the MIPS data bus. Stores to TXDATA
// queue bytes in a FIFO; a baud-timed FSM serializes them LSB first on tx.
// STATUS and BAUDDIV are readable combinationally so software can poll.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic        byte_enable,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        sel,
    output logic        tx,
    output logic        busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    offset;
    logic          wr_txdata;
    logic          wr_status;
    logic          wr_baud;
    logic [15:0]   baud_div;
    logic          ovf;
    logic          active;
    logic [31:0]   status_word;

    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    tx_state_t     state, state_next;
    logic [15:0]   baud_cnt, baud_cnt_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic [7:0]    shift, shift_next;
    logic          tx_next;
    logic          baud_tick;

    // Byte-lane and upper address/data bits carry no meaning for this block
    logic          unused_bits;
    assign unused_bits = ^{byte_enable, dataadr[1:0], writedata[31:16]};

    assign sel       = (dataadr[31:4] == BASE_ADDR[31:4]);
    assign offset    = dataadr[3:2];
    assign wr_txdata = memwrite && sel && (offset == REG_TXDATA);
    assign wr_status = memwrite && sel && (offset == REG_STATUS);
    assign wr_baud   = memwrite && sel && (offset == REG_BAUDDIV);

    assign active    = (state != IDLE);
    assign busy      = active || !fifo_empty;
    assign baud_tick = (baud_cnt == '0);

    mmio_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .din   (writedata[7:0]),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // STATUS word assembly and load-data mux
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        status_word = '0;
        status_word[ST_ACTIVE] = active;
        status_word[ST_EMPTY]  = fifo_empty;
        status_word[ST_FULL]   = fifo_full;
        status_word[ST_OVF]    = ovf;
        status_word[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);

        readdata = '0;
        if (sel) begin
            case (offset)
                REG_STATUS:  readdata = status_word;
                REG_BAUDDIV: readdata = {16'h0, baud_div};
                default:     readdata = '0;
            endcase
        end
    end

    // Baud divisor register and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_div <= DIV_RESET;
            ovf      <= 1'b0;
        end else begin
            // A zero divisor would stall the bit timer, so it is stored as 1
            if (wr_baud)
                baud_div <= (writedata[15:0] == '0) ? 16'd1 : writedata[15:0];
            if (wr_status)
                ovf <= 1'b0;
            else if (wr_txdata && fifo_full && !fifo_pop)
                ovf <= 1'b1;
        end
    end

    // Transmit FSM: next state, FIFO pop, bit timing and the next line level
    always_comb begin
        state_next    = state;
        fifo_pop      = 1'b0;
        baud_cnt_next = baud_cnt;
        bit_cnt_next  = bit_cnt;
        shift_next    = shift;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    shift_next    = fifo_dout;
                    bit_cnt_next  = '0;
                    baud_cnt_next = baud_div - 16'd1;
                    state_next    = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    baud_cnt_next = baud_div - 16'd1;
                    state_next    = DATA;
                end else begin
                    baud_cnt_next = baud_cnt - 16'd1;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    baud_cnt_next = baud_div - 16'd1;
                    shift_next    = shift >> 1;
                    bit_cnt_next  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_next = STOP;
                end else begin
                    baud_cnt_next = baud_cnt - 16'd1;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    // Chain straight into the next frame when more bytes wait
                    if (!fifo_empty) begin
                        fifo_pop      = 1'b1;
                        shift_next    = fifo_dout;
                        bit_cnt_next  = '0;
                        baud_cnt_next = baud_div - 16'd1;
                        state_next    = START;
                    end else begin
                        state_next    = IDLE;
                    end
                end else begin
                    baud_cnt_next = baud_cnt - 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Line level is registered from the next state so tx is glitch-free
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    // Transmit FSM and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_cnt  <= bit_cnt_next;
            shift    <= shift_next;
            tx       <= tx_next;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx. The reference model describes the
// serial line as a sequence of contiguous 8N1 frames computed arithmetically
// from the queued bytes and the divisor; a monitor logs tx/busy every cycle.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE     = 32'hFFFF_0000;
    localparam logic [31:0] A_TXDATA = BASE;
    localparam logic [31:0] A_STATUS = BASE + 32'h4;
    localparam logic [31:0] A_BAUD   = BASE + 32'h8;
    localparam logic [31:0] A_RSVD   = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic        byte_enable = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        sel;
    logic        tx;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: bytes expected on the line, divisor in use
    logic [7:0] byte_q [$];
    int         m_div = 4;

    mmio_uart_tx dut (
        .clk         (clk),
        .reset       (reset),
        .memwrite    (memwrite),
        .byte_enable (byte_enable),
        .dataadr     (dataadr),
        .writedata   (writedata),
        .readdata    (readdata),
        .sel         (sel),
        .tx          (tx),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Edge counter and per-cycle log of the line, sampled mid-cycle
    int   cyc = 0;
    logic log_tx   [0:65535];
    logic log_busy [0:65535];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        log_tx[cyc % 65536]   = tx;
        log_busy[cyc % 65536] = busy;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Expected line level k cycles after the first frame begins
    function automatic logic exp_tx(input int k);
        int         flen;
        int         idx;
        int         slot;
        logic [7:0] b;
        flen = 10 * m_div;
        idx  = k / flen;
        if (idx >= byte_q.size()) return 1'b1;
        slot = (k % flen) / m_div;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        b = byte_q[idx];
        return b[slot-1];
    endfunction

    function automatic logic exp_busy(input int k);
        return (k < byte_q.size() * 10 * m_div);
    endfunction

    // Called just after a falling edge; the store lands on the next rising edge
    task automatic store(input logic [31:0] addr, input logic [31:0] data,
                         input logic sb, output int edge_no);
        dataadr     = addr;
        writedata   = data;
        byte_enable = sb;
        memwrite    = 1'b1;
        edge_no     = cyc + 1;
        @(negedge clk);
        memwrite    = 1'b0;
        byte_enable = 1'b0;
    endtask

    task automatic load(input logic [31:0] addr, output logic [31:0] data);
        memwrite = 1'b0;
        dataadr  = addr;
        #1;
        data = readdata;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_line: tx=%b busy=%b, expected tx=1 busy=0", tx, busy);
        end
        reset = 1'b0;
        load(A_STATUS, rd);
        vectors++;
        if (rd !== 32'h0000_0002 || sel !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_status: got %h sel=%b, expected 00000002 sel=1", rd, sel);
        end
        load(A_BAUD, rd);
        vectors++;
        if (rd !== 32'd434) begin
            miscompares++;
            $display("FAIL reset_bauddiv: got %0d, expected 434", rd);
        end
        @(negedge clk);
    endtask

    task automatic test_single_byte;
        int e;
        bit ok;
        store(A_BAUD, 32'd4, 1'b0, e);
        m_div = 4;
        byte_q.delete();
        byte_q.push_back(8'h55);
        store(A_TXDATA, 32'h0000_0055, 1'b0, e);
        wait_idle(200, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single_timeout: busy=%b, expected 0 within 200 cycles", busy);
        end
        repeat (4) @(negedge clk);
        for (int k = 0; k < 44; k++) begin
            vectors++;
            if (log_tx[(e+1+k) % 65536] !== exp_tx(k) || log_busy[(e+1+k) % 65536] !== exp_busy(k)) begin
                miscompares++;
                $display("FAIL single_wave k=%0d: tx=%b busy=%b, expected tx=%b busy=%b",
                         k, log_tx[(e+1+k) % 65536], log_busy[(e+1+k) % 65536], exp_tx(k), exp_busy(k));
            end
        end
    endtask

    task automatic test_back_to_back;
        int          e0;
        int          e;
        bit          ok;
        logic [31:0] rd;
        m_div = 4;
        byte_q.delete();
        for (int i = 1; i <= 4; i++) begin
            store(A_TXDATA, 32'(i), 1'b0, e);
            if (i == 1) e0 = e;
            byte_q.push_back(8'(i));
        end
        load(A_STATUS, rd);
        vectors++;
        if (rd !== 32'h0000_0031) begin
            miscompares++;
            $display("FAIL b2b_peak_status: got %h, expected 00000031 (count=3 active)", rd);
        end
        wait_idle(400, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL b2b_timeout: busy=%b, expected 0 within 400 cycles", busy);
        end
        repeat (4) @(negedge clk);
        for (int k = 0; k < 164; k++) begin
            vectors++;
            if (log_tx[(e0+1+k) % 65536] !== exp_tx(k) || log_busy[(e0+1+k) % 65536] !== exp_busy(k)) begin
                miscompares++;
                $display("FAIL b2b_wave k=%0d: tx=%b busy=%b, expected tx=%b busy=%b",
                         k, log_tx[(e0+1+k) % 65536], log_busy[(e0+1+k) % 65536], exp_tx(k), exp_busy(k));
            end
        end
        load(A_STATUS, rd);
        vectors++;
        if (rd !== 32'h0000_0002) begin
            miscompares++;
            $display("FAIL b2b_final_status: got %h, expected 00000002 (ovf=0)", rd);
        end
    endtask

    task automatic test_overflow;
        int          e0;
        int          e;
        bit          ok;
        logic [31:0] rd;
        logic [7:0]  b;
        store(A_BAUD, 32'd100, 1'b0, e);
        m_div = 100;
        byte_q.delete();
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            store(A_TXDATA, {24'($urandom), b}, 1'b0, e);
            if (i == 0) e0 = e;
            if (i < 5) byte_q.push_back(b);
        end
        load(A_STATUS, rd);
        vectors++;
        if (rd !== 32'h0000_004D) begin
            miscompares++;
            $display("FAIL ovf_status: got %h, expected 0000004d (count=4 ovf full active)", rd);
        end
        store(A_STATUS, $urandom, 1'b0, e);
        load(A_STATUS, rd);
        vectors++;
        if (rd !== 32'h0000_0045) begin
            miscompares++;
            $display("FAIL ovf_clear: got %h, expected 00000045", rd);
        end
        wait_idle(6000, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL ovf_timeout: busy=%b, expected 0 within 6000 cycles", busy);
        end
        repeat (4) @(negedge clk);
        for (int k = 0; k < 5004; k++) begin
            vectors++;
            if (log_tx[(e0+1+k) % 65536] !== exp_tx(k) || log_busy[(e0+1+k) % 65536] !== exp_busy(k)) begin
                miscompares++;
                $display("FAIL ovf_wave k=%0d: tx=%b busy=%b, expected tx=%b busy=%b",
                         k, log_tx[(e0+1+k) % 65536], log_busy[(e0+1+k) % 65536], exp_tx(k), exp_busy(k));
            end
        end
    endtask

    task automatic test_decode;
        int          e;
        bit          ok;
        logic [31:0] rd;
        // Store just past the window must not reach the FIFO
        dataadr   = BASE + 32'h10;
        writedata = 32'h0000_0077;
        memwrite  = 1'b1;
        #1;
        vectors++;
        if (sel !== 1'b0) begin
            miscompares++;
            $display("FAIL decode_sel_outside: sel=%b, expected 0", sel);
        end
        @(negedge clk);
        memwrite = 1'b0;
        store(A_RSVD, 32'hFFFF_FFFF, 1'b0, e);
        @(negedge clk);
        load(A_STATUS, rd);
        vectors++;
        if (rd !== 32'h0000_0002 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL decode_no_push: status=%h busy=%b, expected 00000002 busy=0", rd, busy);
        end
        load(A_RSVD, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL decode_reserved: got %h, expected 00000000", rd);
        end
        load(A_TXDATA, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL decode_txdata_read: got %h, expected 00000000", rd);
        end
        load(32'h1000_0004, rd);
        vectors++;
        if (rd !== 32'h0 || sel !== 1'b0) begin
            miscompares++;
            $display("FAIL decode_outside_read: got %h sel=%b, expected 00000000 sel=0", rd, sel);
        end
        store(A_BAUD, 32'hFFFF_1234, 1'b0, e);
        load(A_BAUD, rd);
        vectors++;
        if (rd !== 32'h0000_1234) begin
            miscompares++;
            $display("FAIL decode_baud_upper: got %h, expected 00001234", rd);
        end
        store(A_BAUD, 32'h0, 1'b0, e);
        load(A_BAUD, rd);
        vectors++;
        if (rd !== 32'h1) begin
            miscompares++;
            $display("FAIL decode_baud_zero: got %h, expected 00000001", rd);
        end
        m_div = 1;
        byte_q.delete();
        byte_q.push_back(8'hA5);
        store(A_TXDATA, 32'hDEAD_BEA5, 1'b1, e);
        wait_idle(100, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL decode_sb_timeout: busy=%b, expected 0 within 100 cycles", busy);
        end
        repeat (4) @(negedge clk);
        for (int k = 0; k < 14; k++) begin
            vectors++;
            if (log_tx[(e+1+k) % 65536] !== exp_tx(k) || log_busy[(e+1+k) % 65536] !== exp_busy(k)) begin
                miscompares++;
                $display("FAIL decode_sb_wave k=%0d: tx=%b busy=%b, expected tx=%b busy=%b",
                         k, log_tx[(e+1+k) % 65536], log_busy[(e+1+k) % 65536], exp_tx(k), exp_busy(k));
            end
        end
    endtask

    task automatic test_random;
        int          e0;
        int          e;
        int          n;
        int          started;
        int          exp_cnt;
        bit          ok;
        logic [31:0] rd;
        logic [31:0] exp_st;
        logic [7:0]  b;
        for (int it = 0; it < 20; it++) begin
            m_div = $urandom_range(1, 6);
            store(A_BAUD, 32'(m_div), 1'b0, e);
            byte_q.delete();
            n = $urandom_range(1, 4);
            e0 = 0;
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                if (i > 0 && $urandom_range(0, 1) == 1) @(negedge clk);
                store(A_TXDATA, {24'($urandom), b}, 1'($urandom_range(0, 1)), e);
                if (i == 0) e0 = e;
                byte_q.push_back(b);
            end
            // Frame j begins 10*div cycles after frame j-1, the first one edge after the first push
            started = 0;
            for (int j = 0; j < n; j++)
                if (e0 + 1 + j * 10 * m_div <= e) started++;
            exp_cnt = n - started;
            exp_st = '0;
            exp_st[0]   = (started > 0);
            exp_st[1]   = (exp_cnt == 0);
            exp_st[2]   = (exp_cnt == 4);
            exp_st[7:4] = 4'(exp_cnt);
            load(A_STATUS, rd);
            vectors++;
            if (rd !== exp_st) begin
                miscompares++;
                $display("FAIL rand_status it=%0d: got %h, expected %h", it, rd, exp_st);
            end
            wait_idle(400, ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL rand_timeout it=%0d: busy=%b, expected 0 within 400 cycles", it, busy);
            end
            repeat (4) @(negedge clk);
            for (int k = 0; k < n * 10 * m_div + 4; k++) begin
                vectors++;
                if (log_tx[(e0+1+k) % 65536] !== exp_tx(k) || log_busy[(e0+1+k) % 65536] !== exp_busy(k)) begin
                    miscompares++;
                    $display("FAIL rand_wave it=%0d k=%0d: tx=%b busy=%b, expected tx=%b busy=%b",
                             it, k, log_tx[(e0+1+k) % 65536], log_busy[(e0+1+k) % 65536], exp_tx(k), exp_busy(k));
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int          e0;
        int          e;
        bit          bad;
        logic [31:0] rd;
        store(A_BAUD, 32'd4, 1'b0, e);
        m_div = 4;
        byte_q.delete();
        byte_q.push_back(8'h00);
        store(A_TXDATA, 32'h0000_0000, 1'b0, e0);
        store(A_TXDATA, 32'h0000_00C3, 1'b0, e);
        store(A_TXDATA, 32'h0000_0081, 1'b0, e);
        // Data bit 3 occupies edges e0+17..e0+20; reset lands on e0+19
        while (cyc < e0 + 18) @(negedge clk);
        for (int k = 0; k < 18; k++) begin
            vectors++;
            if (log_tx[(e0+1+k) % 65536] !== exp_tx(k)) begin
                miscompares++;
                $display("FAIL rstmid_pre k=%0d: tx=%b, expected %b", k, log_tx[(e0+1+k) % 65536], exp_tx(k));
            end
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_line: tx=%b busy=%b, expected tx=1 busy=0", tx, busy);
        end
        reset = 1'b0;
        load(A_STATUS, rd);
        vectors++;
        if (rd !== 32'h0000_0002) begin
            miscompares++;
            $display("FAIL rstmid_status: got %h, expected 00000002 (count=0)", rd);
        end
        load(A_BAUD, rd);
        vectors++;
        if (rd !== 32'd434) begin
            miscompares++;
            $display("FAIL rstmid_bauddiv: got %0d, expected 434", rd);
        end
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL rstmid_quiet: line activity after reset, tx=%b busy=%b, expected tx=1 busy=0", tx, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_decode();
        test_random();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
